// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: the control inputs, the instruction memory port and the decode-facing stream.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_pc;
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst_out;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [31:0]           fetch_count;
  logic                  halted;

  // Fetch unit side
  modport master (
    input  start, start_pc, stall, redirect_valid, redirect_pc, imem_data,
    output imem_addr, inst_valid, inst_out, inst_pc, fetch_count, halted
  );

  // Control / memory / decode side
  modport slave (
    output start, start_pc, stall, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, inst_valid, inst_out, inst_pc, fetch_count, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: owns the PC, hides the one-cycle memory read
// latency by tagging the word in flight, and supports stall, redirect and halt.
module instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = '1
) (
  input logic                 clock,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] tag_pc;
  logic                  tag_valid;
  logic [31:0]           fetch_count;
  logic                  halted;

  logic                  running;
  logic                  inst_valid;

  assign running    = (state == RUN);
  // A redirect kills the word currently presented in the same cycle.
  assign inst_valid = tag_valid & running & ~bus.redirect_valid;

  assign bus.inst_valid  = inst_valid;
  assign bus.inst_out    = bus.imem_data;
  assign bus.inst_pc     = tag_pc;
  assign bus.fetch_count = fetch_count;
  assign bus.halted      = halted;

  // Memory address: stall re-reads the presented word so imem_data stays stable.
  always_comb begin
    bus.imem_addr = pc;
    if (!running)
      bus.imem_addr = bus.start_pc;
    else if (bus.redirect_valid)
      bus.imem_addr = bus.redirect_pc;
    else if (bus.stall)
      bus.imem_addr = tag_pc;
  end

  // Sequencer state, PC, tag and consumed-instruction counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      tag_pc      <= '0;
      tag_valid   <= 1'b0;
      fetch_count <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (bus.start) begin
            tag_pc    <= bus.start_pc;
            tag_valid <= 1'b1;
            pc        <= bus.start_pc + ADDR_WIDTH'(1);
            state     <= RUN;
            halted    <= 1'b0;
          end
        end
        RUN: begin
          if (bus.redirect_valid) begin
            tag_pc    <= bus.redirect_pc;
            tag_valid <= 1'b1;
            pc        <= bus.redirect_pc + ADDR_WIDTH'(1);
          end else if (!bus.stall && tag_valid) begin
            fetch_count <= fetch_count + 32'd1;
            if (bus.imem_data == HALT_WORD) begin
              state     <= HALTED;
              tag_valid <= 1'b0;
              halted    <= 1'b1;
            end else begin
              tag_pc <= pc;
              pc     <= pc + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          tag_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory image returns word = address,
// halt word set to 9.
module tb_instruction_fetch;

  logic clock;
  logic reset;
  int   total;
  int   passed;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .HALT_WORD  (32'd9)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read instruction memory: word = address.
  always @(posedge clock) bus.imem_data <= 32'(bus.imem_addr);

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic look(input string tag, input logic v, input logic [7:0] pc, input logic [31:0] cnt);
    #1;
    chk({tag, ".valid"}, 32'(bus.inst_valid), 32'(v));
    if (v) begin
      chk({tag, ".pc"},  32'(bus.inst_pc), 32'(pc));
      chk({tag, ".out"}, bus.inst_out, 32'(pc));
    end
    chk({tag, ".count"}, bus.fetch_count, cnt);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    bus.start = 1'b0;
    bus.start_pc = 8'h33;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    cyc();
    cyc();
    #1;
    chk("rst.valid",  32'(bus.inst_valid), 32'd0);
    chk("rst.pc",     32'(bus.inst_pc), 32'd0);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.count",  bus.fetch_count, 32'd0);
    chk("rst.addr",   32'(bus.imem_addr), 32'h33);
    reset = 1'b0;
    cyc();
    chk("idle.valid", 32'(bus.inst_valid), 32'd0);

    // Start at 0: stream 0,1,2,3,4,5
    bus.start = 1'b1; bus.start_pc = 8'h00;
    cyc();
    bus.start = 1'b0;
    look("s0", 1'b1, 8'd0, 32'd0);
    cyc(); look("s1", 1'b1, 8'd1, 32'd1);
    cyc(); look("s2", 1'b1, 8'd2, 32'd2);
    cyc(); look("s3", 1'b1, 8'd3, 32'd3);
    cyc(); look("s4", 1'b1, 8'd4, 32'd4);
    cyc(); look("s5", 1'b1, 8'd5, 32'd5);

    // Stall three cycles on 5, then release
    bus.stall = 1'b1;
    #1; chk("stall.addr", 32'(bus.imem_addr), 32'd5);
    cyc(); look("st1", 1'b1, 8'd5, 32'd5);
    cyc(); look("st2", 1'b1, 8'd5, 32'd5);
    bus.stall = 1'b0;
    cyc(); look("st3", 1'b1, 8'd6, 32'd6);
    cyc(); look("s7", 1'b1, 8'd7, 32'd7);

    // Redirect to 0x40 together with stall
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h40; bus.stall = 1'b1;
    #1;
    chk("redir.valid", 32'(bus.inst_valid), 32'd0);
    chk("redir.addr",  32'(bus.imem_addr), 32'h40);
    cyc();
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    look("r40", 1'b1, 8'h40, 32'd7);
    cyc(); look("r41", 1'b1, 8'h41, 32'd8);

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    chk("arst.valid",  32'(bus.inst_valid), 32'd0);
    chk("arst.halted", 32'(bus.halted), 32'd0);
    chk("arst.count",  bus.fetch_count, 32'd0);
    reset = 1'b0;

    // Wrap-around from 0xFE
    bus.start = 1'b1; bus.start_pc = 8'hFE;
    cyc();
    bus.start = 1'b0;
    look("wFE", 1'b1, 8'hFE, 32'd0);
    cyc(); look("wFF", 1'b1, 8'hFF, 32'd1);
    cyc(); look("w00", 1'b1, 8'h00, 32'd2);
    cyc(); look("w01", 1'b1, 8'h01, 32'd3);
    // start while running is ignored
    bus.start = 1'b1; bus.start_pc = 8'h80;
    cyc();
    bus.start = 1'b0;
    look("w02", 1'b1, 8'h02, 32'd4);

    // Halt on word 9
    reset = 1'b1;
    #2 reset = 1'b0;
    bus.start = 1'b1; bus.start_pc = 8'd7;
    cyc();
    bus.start = 1'b0; bus.start_pc = 8'h55;
    look("h7", 1'b1, 8'd7, 32'd0);
    cyc(); look("h8", 1'b1, 8'd8, 32'd1);
    cyc(); look("h9", 1'b1, 8'd9, 32'd2);
    cyc(); look("hlt", 1'b0, 8'd0, 32'd3);
    chk("hlt.halted", 32'(bus.halted), 32'd1);
    cyc(); look("hlt2", 1'b0, 8'd0, 32'd3);
    chk("hlt2.halted", 32'(bus.halted), 32'd1);
    chk("hlt.addr",    32'(bus.imem_addr), 32'h55);

    // Resume from halt at 2
    bus.start = 1'b1; bus.start_pc = 8'd2;
    cyc();
    bus.start = 1'b0;
    look("res2", 1'b1, 8'd2, 32'd3);
    chk("res.halted", 32'(bus.halted), 32'd0);

    // Reset while stalled, then start from IDLE
    bus.stall = 1'b1;
    cyc();
    look("rs.stall", 1'b1, 8'd2, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("rs.valid", 32'(bus.inst_valid), 32'd0);
    chk("rs.count", bus.fetch_count, 32'd0);
    reset = 1'b0; bus.stall = 1'b0;
    bus.start = 1'b1; bus.start_pc = 8'h10;
    cyc();
    bus.start = 1'b0;
    look("rs.start", 1'b1, 8'h10, 32'd0);
    cyc(); look("rs.next", 1'b1, 8'h11, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Sequencer that drives the synchronous-read instruction memory and presents a stream of fetched instructions, each tagged with its address, to decode. It owns the program counter and compensates for the memory's one-cycle read latency. It supports start, decode back-pressure (stall), branch redirect, and halt-on-sentinel. It sits between the instruction memory and the decode stage of the single-clock datapath.

## Interface
- ADDR_WIDTH, 8: program counter and memory address width (word-addressed).
- DATA_WIDTH, 32: instruction width.
- HALT_WORD, 32'hFFFF_FFFF: instruction value that halts fetch when consumed.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  level/pulse; in IDLE or HALTED, begins fetch at start_pc.
- start_pc  in  ADDR_WIDTH  first fetch address.
- stall  in  1  decode cannot accept the presented instruction this cycle.
- redirect_valid  in  1  branch taken; refetch from redirect_pc.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- imem_addr  out  ADDR_WIDTH  combinational address to instruction memory.
- imem_data  in  DATA_WIDTH  memory output; holds word for the address sampled at previous posedge.
- inst_valid  out  1  inst_out/inst_pc are a live instruction.
- inst_out  out  DATA_WIDTH  = imem_data (pass-through).
- inst_pc  out  ADDR_WIDTH  address of inst_out.
- fetch_count  out  32  number of instructions consumed since reset.
- halted  out  1  high in HALTED state.

## Operation
- States: IDLE (reset), RUN, HALTED. Registers: state, pc, tag_pc, tag_valid, fetch_count.
- Consumed = inst_valid & ~stall at a posedge.
- inst_valid = tag_valid & (state==RUN) & ~redirect_valid (redirect kills the presented instruction combinationally).
- imem_addr selection, in priority order:
  - IDLE/HALTED: start_pc.
  - RUN with redirect_valid: redirect_pc.
  - RUN with stall: tag_pc, so the memory re-reads the presented word and imem_data stays stable.
  - Otherwise: pc.
- IDLE/HALTED, start=1 at posedge:
  - tag_pc<=start_pc, tag_valid<=1, pc<=start_pc+1, state<=RUN, halted<=0.
  - Without start: all registers hold.
- RUN, redirect_valid=1 at posedge (overrides stall and halt):
  - tag_pc<=redirect_pc, tag_valid<=1, pc<=redirect_pc+1.
  - No count increment.
- RUN, stall=1 and no redirect: all registers hold.
- RUN, consumed:
  - fetch_count+1.
  - If inst_out==HALT_WORD: state<=HALTED, tag_valid<=0, pc holds.
  - Else: tag_pc<=pc, pc<=pc+1.
- start during RUN is ignored.
- pc arithmetic is modulo 2^ADDR_WIDTH: 255+1 wraps to 0 at default width. fetch_count wraps modulo 2^32.
- Reset values: state=IDLE, pc=0, tag_pc=0, tag_valid=0, fetch_count=0. Outputs: inst_valid=0, inst_pc=0, halted=0, imem_addr=start_pc.
- Reset mid-RUN or mid-stall: returns to IDLE immediately. The in-flight instruction is discarded and not counted.

## Timing
- Start latency: first inst_valid=1 in the cycle after the start edge, with inst_pc=start_pc.
- Throughput: one instruction per cycle with no stall.
- Stall: the presented instruction stays stable for the entire stall, and releases the cycle stall falls.
- Redirect latency: target instruction valid one cycle after the redirect edge. The redirect cycle itself shows inst_valid=0.
- HALT_WORD consumed at edge N: inst_valid=0 and halted=1 from cycle N+1.
- Combinational paths: redirect_valid and stall to imem_addr; redirect_valid to inst_valid. The memory registers on posedge, so there is no combinational loop.

## Test plan
Memory model returns word = address, matching the team's default instruction image.
- Reset, then start with start_pc=0, no stall: inst_pc/inst_out sequence 0,1,2,3 on consecutive cycles; fetch_count=4 after 4 cycles.
- Stall held 3 cycles while inst_pc=5: inst_out=5 stable for 3 cycles, no count change; next cycle inst_pc=6.
- Redirect to 0x40 while inst_pc=7: inst_valid=0 that cycle, next cycle inst_pc=0x40, then 0x41; redirect asserted together with stall still takes effect.
- start_pc=0xFE: sequence 0xFE, 0xFF, 0x00, 0x01 (wrap-around).
- HALT_WORD=9, start at 7: consume 7, 8, 9; then halted=1, inst_valid=0, fetch_count=3; start with start_pc=2 resumes with inst_pc=2.
- Reset asserted asynchronously mid-stream (between edges): inst_valid, halted, and fetch_count go to 0 immediately; the next start behaves as from IDLE.
